// File: rtl/gpr_wb_ctrl.sv
// Register-file write-port controller: pipeline writeback has priority over a FIFO of long-latency results.
// Optional pending-write compare against decode source registers is enabled with GPR_WB_PEND_EN.
module gpr_wb_ctrl #(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk_,
  input  logic              reset,
  input  logic              wb_en_,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              lr_valid,
  output logic              lr_ready,
  input  logic [ADDR_W-1:0] lr_addr,
  input  logic [DATA_W-1:0] lr_data,
  output logic              stall_req,
  output logic              we_,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] chk_addr_0,
  input  logic [ADDR_W-1:0] chk_addr_1,
  output logic              pend_0,
  output logic              pend_1
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [7:0]       STARVE_C  = 8'(STARVE_MAX);

  logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];

  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [7:0]        starve_q, starve_d;
  logic              stall_q, stall_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  logic              empty_s;
  logic              push_s;
  logic              pop_s;
  logic              collide_s;
  logic [ADDR_W-1:0] head_addr_s;
  logic [DATA_W-1:0] head_data_s;

  assign empty_s     = (count_q == CNT_ZERO);
  assign lr_ready    = (count_q < DEPTH_C);
  assign push_s      = lr_valid & lr_ready;
  assign head_addr_s = fifo_addr_q[rd_ptr_q];
  assign head_data_s = fifo_data_q[rd_ptr_q];
  // An older buffered write to the register the pipeline is writing now is dead; drop it.
  assign collide_s   = ~wb_en_ & ~empty_s & (head_addr_s == wb_addr);
  assign pop_s       = ~empty_s & (wb_en_ | collide_s);

  // Write-port source select: pipeline, else FIFO head, else idle with address/data held.
  always_comb begin
    we_d      = 1'b1;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (!wb_en_) begin
      we_d      = 1'b0;
      wr_addr_d = wb_addr;
      wr_data_d = wb_data;
    end else if (!empty_s) begin
      we_d      = 1'b0;
      wr_addr_d = head_addr_s;
      wr_data_d = head_data_s;
    end else begin
      we_d      = 1'b1;
    end
  end

  // FIFO pointer and occupancy next state.
  always_comb begin
    rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    wr_ptr_d = push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Head starvation counter and the stall request derived from it.
  always_comb begin
    if (empty_s || pop_s) begin
      starve_d = 8'd0;
    end else if (starve_q >= STARVE_C) begin
      starve_d = STARVE_C;
    end else begin
      starve_d = starve_q + 8'd1;
    end
    stall_d = (starve_q >= STARVE_C) || (count_q == DEPTH_C);
  end

  // Control state and registered write port.
  always_ff @(posedge clk_) begin
    if (!reset) begin
      rd_ptr_q  <= {PTR_W{1'b0}};
      wr_ptr_q  <= {PTR_W{1'b0}};
      count_q   <= CNT_ZERO;
      starve_q  <= 8'd0;
      stall_q   <= 1'b0;
      we_q      <= 1'b1;
      wr_addr_q <= {ADDR_W{1'b0}};
      wr_data_q <= {DATA_W{1'b0}};
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      starve_q  <= starve_d;
      stall_q   <= stall_d;
      we_q      <= we_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // FIFO storage; validity is tracked by count_q, so entries need no reset.
  always_ff @(posedge clk_) begin
    if (push_s) begin
      fifo_addr_q[wr_ptr_q] <= lr_addr;
      fifo_data_q[wr_ptr_q] <= lr_data;
    end
  end

  assign we_       = we_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign stall_req = stall_q;

`ifdef GPR_WB_PEND_EN
  logic pend_0_s, pend_1_s;

  // Match decode sources against every live entry plus the one being pushed now.
  always_comb begin
    pend_0_s = push_s & (lr_addr == chk_addr_0);
    pend_1_s = push_s & (lr_addr == chk_addr_1);
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      pend_0_s = pend_0_s | ((CNT_W'(i) < count_q) &
                 (fifo_addr_q[rd_ptr_q + PTR_W'(i)] == chk_addr_0));
      pend_1_s = pend_1_s | ((CNT_W'(i) < count_q) &
                 (fifo_addr_q[rd_ptr_q + PTR_W'(i)] == chk_addr_1));
    end
  end

  assign pend_0 = pend_0_s;
  assign pend_1 = pend_1_s;
`else
  logic pend_unused_s;
  assign pend_unused_s = ^{chk_addr_0, chk_addr_1};
  assign pend_0 = 1'b0;
  assign pend_1 = 1'b0;
`endif

endmodule
